// File: rtl/column_mux_pkg.sv
// Shared types and build-time constants for the column_mux_scheduler slice.
// Holds the scheduler state encoding, derived widths and the enabled-column search helper.
package column_mux_pkg;

    localparam int GAMMA_CYCLE_LENGTH = 18;
    localparam int NUM_COLUMNS        = 4;
    localparam int NUM_INPUTS         = 16;
    localparam int SETTLE_CYCLES      = 2;

    localparam int COL_SEL_W = $clog2(NUM_COLUMNS);
    localparam int GAMMA_W   = $clog2(GAMMA_CYCLE_LENGTH);
    localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        DONE
    } state_t;

    typedef struct packed {
        logic                 found;
        logic [COL_SEL_W-1:0] idx;
    } col_pick_t;

    // Lowest enabled column whose index is >= first; found=0 when none remains.
    function automatic col_pick_t next_column(input logic [NUM_COLUMNS-1:0] mask,
                                              input int first);
        col_pick_t pick;
        pick = '0;
        for (int i = NUM_COLUMNS - 1; i >= 0; i--) begin
            if (i >= first && mask[i]) begin
                pick.found = 1'b1;
                pick.idx   = COL_SEL_W'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Gamma-cycle counter: counts 0..LENGTH-1 while start_count is high, wrapping at the end.
// Holds 0 whenever start_count is low or clear is asserted.
module cycle_counter #(
    parameter int LENGTH = 18,
    parameter int W      = $clog2(LENGTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         start_count,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear || !start_count) begin
            count <= '0;
        end else if (count == W'(LENGTH - 1)) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/column_mux_scheduler.sv
// Time-shares one physical column across NUM_COLUMNS weight contexts per input volley.
// Optional macro COL_MASK_EN adds a per-frame col_enable mask that skips disabled columns.
module column_mux_scheduler
    import column_mux_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
`ifdef COL_MASK_EN
    input  logic [NUM_COLUMNS-1:0] col_enable,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_INPUTS-1:0]  in_spikes,
    output logic [NUM_INPUTS-1:0]  volley_q,
    output logic [COL_SEL_W-1:0]   col_sel,
    output logic                   clear_body,
    output logic [GAMMA_W-1:0]     gamma_count,
    output logic                   run,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   frame_done,
    input  logic                   abort
);

    state_t                 state_q;
    state_t                 state_d;
    logic [SETTLE_W-1:0]    settle_cnt;
    logic [NUM_COLUMNS-1:0] accept_mask;
    logic [NUM_COLUMNS-1:0] mask_q;
    col_pick_t              first_pick;
    col_pick_t              next_pick;
    logic                   accept;
    logic                   abort_hit;
    logic                   advance;

`ifdef COL_MASK_EN
    assign accept_mask = col_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= col_enable;
        end
    end
`else
    assign accept_mask = '1;
    assign mask_q      = '1;
`endif

    assign accept     = (state_q == IDLE) && in_valid;
    assign abort_hit  = abort && (state_q != IDLE);
    assign first_pick = next_column(accept_mask, 0);
    assign next_pick  = next_column(mask_q, int'(col_sel) + 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        advance = 1'b0;
        case (state_q)
            IDLE:    if (accept) state_d = first_pick.found ? LOAD : DONE;
            LOAD:    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) state_d = RUN;
            RUN:     if (gamma_count == GAMMA_W'(GAMMA_CYCLE_LENGTH - 1)) state_d = CAPTURE;
            CAPTURE: begin
                if (out_ready) begin
                    if (next_pick.found) begin
                        advance = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort outranks a same-cycle capture handshake.
        if (abort_hit) begin
            state_d = IDLE;
            advance = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            volley_q   <= '0;
            col_sel    <= '0;
            settle_cnt <= '0;
        end else begin
            if (accept) begin
                volley_q <= in_spikes;
                col_sel  <= first_pick.found ? first_pick.idx : '0;
            end else if (advance) begin
                col_sel  <= next_pick.idx;
            end
            settle_cnt <= (state_q == LOAD && state_d == LOAD) ? settle_cnt + SETTLE_W'(1) : '0;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign clear_body = (state_q == LOAD) && (settle_cnt == '0);
    assign run        = (state_q == RUN);
    assign out_valid  = (state_q == CAPTURE);
    assign frame_done = (state_q == DONE);

    cycle_counter #(
        .LENGTH (GAMMA_CYCLE_LENGTH),
        .W      (GAMMA_W)
    ) u_gamma_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (abort_hit),
        .start_count (state_q == RUN),
        .count       (gamma_count)
    );

endmodule

// File: tb/tb_column_mux_scheduler.sv
// Directed bench for column_mux_scheduler: frame timing, backpressure, abort, streaming, reset.
// Define COL_MASK_EN for both bench and RTL to exercise the column mask.
module tb_column_mux_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_spikes;
    logic [15:0] volley_q;
    logic [1:0]  col_sel;
    logic        clear_body;
    logic [4:0]  gamma_count;
    logic        run;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;
    logic        abort;
`ifdef COL_MASK_EN
    logic [3:0]  col_enable = 4'b1111;
`endif

    int total = 0;
    int bad   = 0;

    // per-frame observations, indexed by cycles since accept
    int          done_at;
    int          n_clear;
    int          n_run;
    int          vol_bad;
    int          clr_at [8];
    int          clr_col[8];
    logic [15:0] exp_volley;

    always #5 clk = ~clk;

    column_mux_scheduler dut (
        .clk         (clk),
        .rst         (rst),
`ifdef COL_MASK_EN
        .col_enable  (col_enable),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_spikes   (in_spikes),
        .volley_q    (volley_q),
        .col_sel     (col_sel),
        .clear_body  (clear_body),
        .gamma_count (gamma_count),
        .run         (run),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_done  (frame_done),
        .abort       (abort)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a volley in the current (IDLE) cycle, which becomes cycle 0 of the frame.
    task automatic start_frame(input logic [15:0] spikes);
        in_valid   = 1'b1;
        in_spikes  = spikes;
        exp_volley = spikes;
        done_at    = -1;
        n_clear    = 0;
        n_run      = 0;
        vol_bad    = 0;
    endtask

    // Advance to frame cycle k and record what the DUT shows there.
    task automatic step(input int k);
        @(posedge clk);
        #1;
        if (k == 1) in_valid = 1'b0;
        if (clear_body) begin
            if (n_clear < 8) begin
                clr_at[n_clear]  = k;
                clr_col[n_clear] = int'(col_sel);
            end
            n_clear++;
        end
        if (run) n_run++;
        if (frame_done && done_at < 0) done_at = k;
        if (volley_q !== exp_volley) vol_bad++;
    endtask

    initial begin
        int ov_bad;
        int n_acc;
        int last_acc;
        int n_done;
        int last_done;
        int order_bad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_spikes = '0;
        out_ready = 1'b1;
        abort     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {clear_body, run, out_valid, frame_done}, 4'b0000);
        check("rst_volley", volley_q, 16'h0000);
        check("rst_col_gamma", {col_sel, gamma_count}, 0);

        // 1: basic frame with zero-wait collector
        start_frame(16'hA5A5);
        for (int k = 1; k <= 90; k++) begin
            step(k);
            if (k == 1)  check("t1_in_ready_busy", in_ready, 0);
            if (k == 3)  check("t1_run_start", {run, gamma_count}, {1'b1, 5'd0});
            if (k == 20) check("t1_run_last", {run, gamma_count}, {1'b1, 5'd17});
            if (k == 21) check("t1_capture", {out_valid, run, gamma_count}, {1'b1, 1'b0, 5'd0});
            if (k == 86) check("t1_idle_after", {in_ready, frame_done}, 2'b10);
        end
        check("t1_done_at", done_at, 85);
        check("t1_n_clear", n_clear, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_clear_at%0d", i), clr_at[i], 1 + 21 * i);
            check($sformatf("t1_clear_col%0d", i), clr_col[i], i);
        end
        check("t1_run_cycles", n_run, 72);
        check("t1_volley", vol_bad, 0);

        // 2: collector stalls five cycles in column 1's capture
        start_frame(16'h3C3C);
        ov_bad = 0;
        for (int k = 1; k <= 95; k++) begin
            step(k);
            if (k >= 42 && k <= 47 && (!out_valid || col_sel != 2'd1)) ov_bad++;
            out_ready = !(k >= 42 && k <= 46);
        end
        check("t2_stall_stable", ov_bad, 0);
        check("t2_done_at", done_at, 90);
        check("t2_volley", vol_bad, 0);

        // 3: abort at gamma_count 7 of column 2, then restart
        start_frame(16'h0F0F);
        for (int k = 1; k <= 52; k++) step(k);
        check("t3_pre_abort", {run, col_sel, gamma_count}, {1'b1, 2'd2, 5'd7});
        abort     = 1'b1;
        in_spikes = 16'hFFFF;
        step(53);
        abort = 1'b0;
        check("t3_after_abort", {in_ready, run, out_valid, clear_body, frame_done}, 5'b10000);
        check("t3_gamma_zero", gamma_count, 0);
        check("t3_volley_kept", volley_q, 16'h0F0F);
        for (int k = 54; k <= 58; k++) step(k);
        check("t3_no_done", done_at, -1);
        start_frame(16'h1234);
        step(1);
        check("t3_restart", {clear_body, col_sel, volley_q}, {1'b1, 2'd0, 16'h1234});
        for (int k = 2; k <= 90; k++) step(k);
        check("t3_restart_done", done_at, 85);

        // 4: in_valid held high across three frames
        in_valid  = 1'b1;
        in_spikes = 16'h5A5A;
        n_acc     = 0;
        last_acc  = -1;
        n_done    = 0;
        last_done = -1;
        order_bad = 0;
        for (int k = 0; k <= 257; k++) begin
            if (in_ready) begin
                n_acc++;
                last_acc = k;
                if (k > 0 && k != last_done + 1) order_bad++;
            end
            if (frame_done) begin
                n_done++;
                last_done = k;
            end
            if (k == 257) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check("t4_accepts", n_acc, 3);
        check("t4_last_accept", last_acc, 172);
        check("t4_dones", n_done, 3);
        check("t4_last_done", last_done, 257);
        check("t4_accept_order", order_bad, 0);

`ifdef COL_MASK_EN
        // 5: column mask
        col_enable = 4'b1010;
        start_frame(16'h00FF);
        for (int k = 1; k <= 50; k++) step(k);
        check("t5_done_at", done_at, 43);
        check("t5_n_clear", n_clear, 2);
        check("t5_cols", {clr_col[0][1:0], clr_col[1][1:0]}, {2'd1, 2'd3});
        check("t5_clear_at", clr_at[1], 22);
        check("t5_run_cycles", n_run, 36);
        col_enable = 4'b0000;
        start_frame(16'hFF00);
        step(1);
        check("t5_empty_done", {frame_done, clear_body, out_valid}, 3'b100);
        step(2);
        check("t5_empty_idle", {in_ready, frame_done}, 2'b10);
        col_enable = 4'b1111;
`endif

        // 6: reset during column 1's settle
        start_frame(16'hC3C3);
        for (int k = 1; k <= 22; k++) step(k);
        check("t6_in_load", {clear_body, col_sel}, {1'b1, 2'd1});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_rst_ctrl", {in_ready, clear_body, run, out_valid, frame_done}, 5'b10000);
        check("t6_rst_data", {volley_q, col_sel, gamma_count}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on simulated time so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/column_mux_scheduler.md
Name: column_mux_scheduler

Overview:
Sequences one physical macro column across NUM_COLUMNS virtual columns (weight contexts) within a frame. Each column gets one gamma cycle. The block:
- accepts one input spike volley per frame via valid/ready and holds it for the whole frame;
- for each column in turn: selects the weight context, pulses a body-potential clear, runs the gamma-cycle counter, then presents a capture handshake to the output collector.

It sits between the volley source and the shared column datapath.

Parameters:
GAMMA_CYCLE_LENGTH, 18, clock cycles per gamma cycle; counter counts 0..GAMMA_CYCLE_LENGTH-1
NUM_COLUMNS, 4, virtual columns time-sharing the physical column; must be >= 2
NUM_INPUTS, 16, spike lines per input volley
SETTLE_CYCLES, 2, weight-select settle cycles before each gamma cycle; must be >= 1

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input volley available
in_ready  output  1  scheduler can accept a volley
in_spikes  input  NUM_INPUTS  input volley, sampled on accept
volley_q  output  NUM_INPUTS  latched volley, held for the whole frame
col_sel  output  $clog2(NUM_COLUMNS)  active virtual column index
clear_body  output  1  one-cycle pulse that clears neuron body potentials
gamma_count  output  $clog2(GAMMA_CYCLE_LENGTH)  current gamma-cycle cycle index
run  output  1  high during the gamma cycle of the active column
out_valid  output  1  active column's result is ready to be captured
out_ready  input  1  collector accepts the result
frame_done  output  1  one-cycle pulse when every column of the frame is finished
abort  input  1  cancel the current frame

Behaviour:
- Reset values: state IDLE; in_ready=1, all other outputs 0, volley_q=0, col_sel=0, gamma_count=0.
- IDLE:
  - in_ready=1.
  - A cycle with in_valid&&in_ready latches in_spikes into volley_q, sets col_sel to the first column, and moves to LOAD on the next cycle.
- LOAD:
  - Lasts SETTLE_CYCLES cycles.
  - clear_body is high on the first LOAD cycle only.
  - After SETTLE_CYCLES cycles, move to RUN.
- RUN:
  - run=1 and the counter's enable is high.
  - gamma_count reads 0 on the first RUN cycle and increments by 1 each cycle.
  - On the cycle gamma_count==GAMMA_CYCLE_LENGTH-1, move to CAPTURE.
  - The enable drops in CAPTURE, so gamma_count returns to 0 the cycle after the last RUN cycle.
  - RUN lasts exactly GAMMA_CYCLE_LENGTH cycles.
- CAPTURE:
  - out_valid=1 and is held stable, with col_sel unchanged, until out_ready.
  - On out_valid&&out_ready:
    - if a further column remains, col_sel advances and the next state is LOAD;
    - otherwise the next state is DONE.
  - Zero-wait per-column latency is SETTLE_CYCLES+GAMMA_CYCLE_LENGTH+1 cycles (21 at defaults).
- DONE:
  - frame_done=1 for one cycle, then IDLE.
  - in_ready returns high in IDLE.
- in_ready is 0 in every state except IDLE; there is no accept-while-busy.
- col_sel wraps to 0 at the start of each new frame, never in the middle of a frame.
- abort:
  - Sampled in any non-IDLE state.
  - The next state is IDLE; run, out_valid and clear_body drop immediately on the next cycle; gamma_count returns to 0; no frame_done pulse is issued.
  - volley_q keeps its value until the next accept.
  - abort in IDLE has no effect and does not block a same-cycle accept.
- abort together with out_valid&&out_ready: abort wins, so no advance.
- rst mid-frame behaves like abort, and additionally clears volley_q.

Optional Feature:
COL_MASK_EN:
- Defined:
  - Adds input col_enable [NUM_COLUMNS], sampled on the accept cycle and held for the frame.
  - Columns with a 0 bit are skipped entirely (no LOAD/RUN/CAPTURE).
  - col_sel moves to the lowest enabled index, and then to the next higher enabled index.
  - An all-zero mask goes from accept directly to DONE: frame_done fires 1 cycle after accept, with no clear_body and no out_valid.
- Undefined: every column runs in every frame; no extra port.

Decomposition:
- Package column_mux_pkg:
  - state enum: IDLE, LOAD, RUN, CAPTURE, DONE;
  - localparam width constants for col_sel, gamma_count and the settle counter.
- One sub-module: the team's existing cycle_counter, instantiated with GAMMA_CYCLE_LENGTH. Its start_count input is driven by the RUN state and its counter output drives gamma_count.
- The FSM, settle counter and column pointer stay in column_mux_scheduler.

Test Plan:
1. Basic frame, defaults, out_ready tied 1, in_spikes=16'hA5A5 accepted at cycle T:
   - clear_body pulses at T+1, T+22, T+43 and T+64;
   - col_sel takes values 0,1,2,3;
   - run is high for 18 cycles per column;
   - frame_done fires at T+85;
   - volley_q==16'hA5A5 throughout.
2. Backpressure: out_ready held 0 for 5 cycles in column 1's CAPTURE:
   - out_valid and col_sel=1 stay stable;
   - frame_done is delayed by exactly 5 cycles.
3. Abort on RUN cycle gamma_count==7 of column 2:
   - next cycle: IDLE, run=0, gamma_count=0, in_ready=1, no frame_done;
   - a new accept restarts at col_sel=0.
4. in_valid held high continuously for 3 frames:
   - exactly one accept per frame, each on the cycle after frame_done;
   - in_ready stays low during every frame.
5. COL_MASK_EN, col_enable=4'b1010:
   - only columns 1 and 3 run; frame_done is 43 cycles after accept.
   - With col_enable=0: frame_done fires 1 cycle after accept.
6. rst asserted during LOAD:
   - next cycle: every output at its reset value, including volley_q=0.
